// File: rtl/seq_detect_scheduler.sv
// Round-robin frame scheduler for a serial Mealy 4-bit sequence detector.
// A granted 4-bit frame is realigned with a one-cycle detector reset, shifted
// out MSB first, and the detector's decision on the last bit becomes the
// result reported to the owning requester.
module seq_detect_scheduler #(
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic [3:0] frame0,
    input  logic [3:0] frame1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       det_rst_n,
    output logic       det_in,
    input  logic       det_dec,
    output logic       done0,
    output logic       done1,
    output logic       match,
    output logic       busy,
    output logic [7:0] match_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        SHIFT,
        RESULT,
        GAP
    } state_t;

    // Loaded on entry to GAP; the GAP state ends once this counts down to zero.
    localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] frame_q, frame_d;
    logic       owner_q, owner_d;   // requester owning the frame in flight
    logic       last_q,  last_d;    // requester served most recently
    logic [1:0] idx_q,   idx_d;     // bit index being shifted, 3 down to 0
    logic [3:0] gap_q,   gap_d;
    logic       match_q, match_d;
    logic [7:0] cnt_q,   cnt_d;

    logic any_req;
    logic pick;
    logic arb_slot;

    // Round-robin pick: a sole requester wins, a tie goes to the one not served last.
    always_comb begin
        any_req = req0 | req1;
        pick    = (req0 && req1) ? ~last_q : req1;
    end

    // Next-state and datapath updates for the frame sequencer.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
        state_d = state_q;
        frame_d = frame_q;
        owner_d = owner_q;
        last_d  = last_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        match_d = match_q;
        cnt_d   = cnt_q;

        // The final cycle of a frame's tail doubles as the arbitration slot,
        // so back-to-back frames repeat every 6 + GAP_CYCLES cycles.
        arb_slot = (state_q == IDLE)
                || (state_q == RESULT && GAP_CYCLES == 0)
                || (state_q == GAP && gap_q == 4'd0);

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            SYNC: begin
                state_d = SHIFT;
                idx_d   = 2'd3;
            end
            SHIFT: begin
                if (idx_q == 2'd0) begin
                    // Decision arrives with the last bit; the count is updated at
                    // the same edge so it is already current during RESULT.
                    state_d = RESULT;
                    match_d = det_dec;
                    if (det_dec && cnt_q != 8'hFF) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else begin
                    idx_d = idx_q - 2'd1;
                end
            end
            RESULT: begin
                if (GAP_CYCLES != 0) begin
                    state_d = GAP;
                    gap_d   = GAP_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            GAP: begin
                if (gap_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A winning request latches its frame so later input changes cannot disturb it.
        if (arb_slot && any_req) begin
            state_d = SYNC;
            owner_d = pick;
            last_d  = pick;
            frame_d = pick ? frame1 : frame0;
            idx_d   = 2'd3;
        end
    end

    // State register with asynchronous reset; the last-served pointer favours requester 0 after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q <= IDLE;
            frame_q <= 4'd0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            idx_q   <= 2'd3;
            gap_q   <= 4'd0;
            match_q <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            match_q <= match_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decoded from registered state; the detector is also held in reset while rst is high.
    always_comb begin
        gnt0      = (state_q == SYNC)   && !owner_q;
        gnt1      = (state_q == SYNC)   &&  owner_q;
        done0     = (state_q == RESULT) && !owner_q;
        done1     = (state_q == RESULT) &&  owner_q;
        det_rst_n = !rst && (state_q != SYNC);
        det_in    = (state_q == SHIFT) ? frame_q[idx_q] : 1'b0;
        busy      = (state_q != IDLE);
        match     = match_q;
        match_cnt = cnt_q;
    end

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Scoreboard bench for seq_detect_scheduler: one instance with GAP_CYCLES=0
// for directed frames, arbitration and reset abort, one with GAP_CYCLES=3 for
// the saturation run. Each instance is paired with a Mealy detector model.
module tb_seq_detect_scheduler;

    typedef struct packed {
        logic       owner;
        logic [3:0] frame;
        logic       match;
        logic [7:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    // Instance A (GAP_CYCLES = 0)
    logic       req0_a = 1'b0, req1_a = 1'b0;
    logic [3:0] frame0_a = 4'd0, frame1_a = 4'd0;
    logic       gnt0_a, gnt1_a, det_rst_n_a, det_in_a, det_dec_a;
    logic       done0_a, done1_a, match_a, busy_a;
    logic [7:0] match_cnt_a;

    // Instance B (GAP_CYCLES = 3)
    logic       req0_b = 1'b0;
    logic       req1_b = 1'b0;
    logic [3:0] frame0_b = 4'd0;
    logic [3:0] frame1_b = 4'd0;
    logic       gnt0_b, gnt1_b, det_rst_n_b, det_in_b, det_dec_b;
    logic       done0_b, done1_b, match_b, busy_b;
    logic [7:0] match_cnt_b;

    seq_detect_scheduler #(.GAP_CYCLES(0)) dut_a (
        .clk(clk), .rst(rst), .req0(req0_a), .req1(req1_a),
        .frame0(frame0_a), .frame1(frame1_a), .gnt0(gnt0_a), .gnt1(gnt1_a),
        .det_rst_n(det_rst_n_a), .det_in(det_in_a), .det_dec(det_dec_a),
        .done0(done0_a), .done1(done1_a), .match(match_a), .busy(busy_a),
        .match_cnt(match_cnt_a)
    );

    seq_detect_scheduler #(.GAP_CYCLES(3)) dut_b (
        .clk(clk), .rst(rst), .req0(req0_b), .req1(req1_b),
        .frame0(frame0_b), .frame1(frame1_b), .gnt0(gnt0_b), .gnt1(gnt1_b),
        .det_rst_n(det_rst_n_b), .det_in(det_in_b), .det_dec(det_dec_b),
        .done0(done0_b), .done1(done1_b), .match(match_b), .busy(busy_b),
        .match_cnt(match_cnt_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Mealy detector models: 4-bit windows aligned by det_rst_n, dec on the
    // final bit of 1001, 0111 or 1110.
    logic [2:0] hist_a, hist_b;
    logic [1:0] dcnt_a, dcnt_b;
    always @(posedge clk) begin
        if (!det_rst_n_a) begin
            hist_a <= 3'd0;
            dcnt_a <= 2'd0;
        end else begin
            hist_a <= {hist_a[1:0], det_in_a};
            dcnt_a <= dcnt_a + 2'd1;
        end
        if (!det_rst_n_b) begin
            hist_b <= 3'd0;
            dcnt_b <= 2'd0;
        end else begin
            hist_b <= {hist_b[1:0], det_in_b};
            dcnt_b <= dcnt_b + 2'd1;
        end
    end
    assign det_dec_a = (dcnt_a == 2'd3) && ({hist_a, det_in_a} inside {4'b1001, 4'b0111, 4'b1110});
    assign det_dec_b = (dcnt_b == 2'd3) && ({hist_b, det_in_b} inside {4'b1001, 4'b0111, 4'b1110});

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard A
    exp_t sb_a[$];
    exp_t cur_a;
    logic [7:0] exp_cnt_a = 8'd0;
    int   done_target_a = 0;
    int   done_cnt_a = 0;
    bit   active_a = 1'b0;
    int   g_cyc_a = 0;
    int   dist_a;

    task automatic push_a(input logic owner, input logic [3:0] f, input logic m);
        exp_t e;
        if (m && exp_cnt_a != 8'hFF) exp_cnt_a = exp_cnt_a + 8'd1;
        e.owner = owner;
        e.frame = f;
        e.match = m;
        e.cnt   = exp_cnt_a;
        sb_a.push_back(e);
        done_target_a++;
    endtask

    // Monitor A: grant owner, serial bits, result timing/content, pulse exclusivity.
    always @(negedge clk) begin
        if (rst) begin
            active_a = 1'b0;
        end else begin
            if (gnt0_a || gnt1_a) begin
                check("a_gnt_expected", sb_a.size() > 0, 1);
                if (sb_a.size() > 0) begin
                    cur_a    = sb_a[0];
                    active_a = 1'b1;
                    g_cyc_a  = cyc;
                    check("a_gnt_owner", gnt1_a, cur_a.owner);
                end
            end else if (active_a) begin
                dist_a = cyc - g_cyc_a;
                if (dist_a >= 1 && dist_a <= 4)
                    check("a_det_in", det_in_a, cur_a.frame[4 - dist_a]);
            end
            if (done0_a || done1_a) begin
                check("a_done_expected", active_a, 1);
                if (active_a) begin
                    check("a_done_latency", cyc - g_cyc_a, 5);
                    check("a_done_owner", done1_a, cur_a.owner);
                    check("a_match", match_a, cur_a.match);
                    check("a_match_cnt", match_cnt_a, cur_a.cnt);
                    void'(sb_a.pop_front());
                    active_a = 1'b0;
                    done_cnt_a++;
                end
            end
        end
        check("a_pulse_exclusive", $countones({gnt0_a, gnt1_a, done0_a, done1_a}) <= 1, 1);
    end

    // Scoreboard B
    exp_t sb_b[$];
    logic [7:0] exp_cnt_b = 8'd0;
    int   done_cnt_b = 0;
    int   prev_done_b = -1;

    // Monitor B: every result, frame period and saturation.
    always @(negedge clk) begin
        if (!rst && (done0_b || done1_b)) begin
            check("b_done_expected", sb_b.size() > 0, 1);
            check("b_done_owner", done1_b, 0);
            if (sb_b.size() > 0) begin
                check("b_match", match_b, sb_b[0].match);
                check("b_match_cnt", match_cnt_b, sb_b[0].cnt);
                void'(sb_b.pop_front());
            end
            if (prev_done_b >= 0) check("b_period", cyc - prev_done_b, 9);
            prev_done_b = cyc;
            done_cnt_b++;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pulses"}, {gnt0_a, gnt1_a, done0_a, done1_a, det_in_a, busy_a}, 0);
        check({tag, "_det_rst_n"}, det_rst_n_a, 0);
        check({tag, "_match"}, match_a, 0);
        check({tag, "_match_cnt"}, match_cnt_a, 0);
    endtask

    task automatic wait_gnt(input logic who, input bit drop, output int at);
        bit found = 1'b0;
        at = -1;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (who ? gnt1_a : gnt0_a) begin
                found = 1'b1;
                at    = cyc;
                if (drop) begin
                    if (who) req1_a = 1'b0;
                    else     req0_a = 1'b0;
                end
            end
        end
        check("a_gnt_seen", found, 1);
    endtask

    task automatic wait_done_a();
        for (int i = 0; i < 60 && done_cnt_a < done_target_a; i++) begin
            @(negedge clk);
            #1;
        end
        check("a_done_count", done_cnt_a, done_target_a);
    endtask

    // One frame from a sole requester; the frame input is scrambled after gnt.
    task automatic send_a(input logic who, input logic [3:0] f, input logic m);
        int at;
        push_a(who, f, m);
        if (who) begin frame1_a = f; req1_a = 1'b1; end
        else     begin frame0_a = f; req0_a = 1'b1; end
        wait_gnt(who, 1'b1, at);
        if (who) frame1_a = ~f;
        else     frame0_a = ~f;
        wait_done_a();
    endtask

    initial begin
        int g0, g1, gcount;
        logic [7:0] m;

        // Reset state, checked asynchronously before any clock edge.
        #2 rst = 1'b1;
        #1 check_reset_outputs("reset_initial");
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Directed single frames: 1001 matches, 1010 does not.
        send_a(1'b0, 4'b1001, 1'b1);
        send_a(1'b1, 4'b1010, 1'b0);
        send_a(1'b1, 4'b1001, 1'b1);
        send_a(1'b0, 4'b0000, 1'b0);
        check("a_cnt_after_singles", match_cnt_a, 2);

        // Reset clears the count before the tie test.
        @(negedge clk);
        rst = 1'b1;
        #1 check_reset_outputs("reset_pulse");
        exp_cnt_a = 8'd0;
        @(negedge clk);
        rst = 1'b0;

        // Simultaneous requests: requester 0 wins the first tie, frames 6 cycles apart.
        push_a(1'b0, 4'b0111, 1'b1);
        push_a(1'b1, 4'b1110, 1'b1);
        frame0_a = 4'b0111;
        frame1_a = 4'b1110;
        req0_a   = 1'b1;
        req1_a   = 1'b1;
        wait_gnt(1'b0, 1'b1, g0);
        wait_gnt(1'b1, 1'b1, g1);
        check("a_tie_spacing", g1 - g0, 6);
        wait_done_a();
        check("a_cnt_after_tie", match_cnt_a, 2);

        // Reset during the third SHIFT cycle aborts the frame; held req0 is re-granted.
        push_a(1'b0, 4'b1001, 1'b1);
        frame0_a = 4'b1001;
        req0_a   = 1'b1;
        wait_gnt(1'b0, 1'b0, g0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs("reset_abort");
        sb_a.delete();
        exp_cnt_a     = 8'd0;
        done_target_a = done_cnt_a;
        push_a(1'b0, 4'b1001, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_gnt(1'b0, 1'b1, g0);
        wait_done_a();

        // GAP_CYCLES=3: 300 continuous 1001 frames, period 9, count saturates.
        for (int i = 0; i < 300; i++) begin
            m = (exp_cnt_b != 8'hFF) ? exp_cnt_b + 8'd1 : exp_cnt_b;
            exp_cnt_b = m;
            sb_b.push_back({1'b0, 4'b1001, 1'b1, m});
        end
        frame0_b = 4'b1001;
        req0_b   = 1'b1;
        gcount   = 0;
        for (int i = 0; i < 300 * 9 + 40 && gcount < 300; i++) begin
            @(negedge clk);
            if (gnt0_b) gcount++;
            if (gcount == 300) req0_b = 1'b0;
        end
        check("b_grant_count", gcount, 300);
        for (int i = 0; i < 40 && done_cnt_b < 300; i++) begin
            @(negedge clk);
            #1;
        end
        check("b_done_count", done_cnt_b, 300);
        check("b_cnt_saturated", match_cnt_b, 255);
        check("b_queue_empty", sb_b.size(), 0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_detect_scheduler.md
SEQ_DETECT_SCHEDULER -- requirements
Module: seq_detect_scheduler

Interface
REQ-001 Parameter: GAP_CYCLES, default 0, number of extra idle cycles inserted after each frame's result cycle before the next grant (legal 0..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req0 / req1  input  1 each  requester frame request; held high with frame stable until the matching gnt pulse.
REQ-005 frame0 / frame1  input  4 each  4-bit frame of requester 0/1, transmitted MSB first.
REQ-006 gnt0 / gnt1  output  1 each  one-cycle pulse: frame of that requester accepted.
REQ-007 det_rst_n  output  1  synchronous active-low reset to the Mealy 4-bit detector; realigns its bit counter.
REQ-008 det_in  output  1  serial bit driven to the detector.
REQ-009 det_dec  input  1  detector's combinational Mealy decision output.
REQ-010 done0 / done1  output  1 each  one-cycle pulse: result for that requester is valid on match.
REQ-011 match  output  1  detection result of the last completed frame; held until the next result.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 match_cnt  output  8  saturating count of frames with match=1.

Function
REQ-014 FSM states: IDLE, SYNC, SHIFT, RESULT, GAP; all outputs registered or decoded from registered state only.
REQ-015 IDLE: if req0 or req1 high, at the next edge latch the winner's frame and owner, pulse its gnt for the following cycle, go to SYNC; else stay.
REQ-016 Arbitration is round-robin: sole requester wins; if both request, the one not served last wins; last-served pointer resets to requester 1 so requester 0 wins the first tie.
REQ-017 SYNC lasts exactly 1 cycle with det_rst_n=0; det_rst_n=1 in all other states.
REQ-018 SHIFT lasts exactly 4 cycles with bit index 3,2,1,0; det_in = latched frame[index]; det_in=0 outside SHIFT.
REQ-019 On the edge ending the index-0 SHIFT cycle, det_dec is sampled into match and state goes to RESULT.
REQ-020 RESULT lasts 1 cycle: done of the owner high, other done low; match_cnt increments if match=1 and match_cnt<255, saturates at 255.
REQ-021 After RESULT: GAP for GAP_CYCLES cycles when GAP_CYCLES>0, else directly IDLE; GAP then IDLE.
REQ-022 Latency: req seen in IDLE at edge E -> gnt high cycle E+1 (SYNC), first bit cycle E+2, done cycle E+6; back-to-back frames occupy 6+GAP_CYCLES cycles each.
REQ-023 Requests arriving while busy are ignored until IDLE; req still high in IDLE after its own done is treated as a new frame.
REQ-024 Changes on req/frame after gnt do not affect the frame in flight.
REQ-025 gnt0, gnt1, done0, done1 never high simultaneously with each other.

Reset
REQ-026 rst high, any state: immediately state=IDLE, gnt0=gnt1=done0=done1=0, det_in=0, det_rst_n=0 while rst is high, match=0, match_cnt=0, busy=0, last-served pointer=requester 1.
REQ-027 Reset mid-frame aborts it with no done pulse; first frame after rst release is restarted from SYNC.

Verification
REQ-028 Bench pairs the block with a 4-bit Mealy detector model asserting dec on final bit of 1001, 0111, 1110 (counter realigned by det_rst_n).
REQ-029 req0=1, frame0=4'b1001 -> gnt0 one cycle later, det_in 1,0,0,1 in 4 consecutive cycles, done0 and match=1 at +6, match_cnt=1.
REQ-030 req1=1, frame1=4'b1010 -> done1 at +6 with match=0, match_cnt unchanged.
REQ-031 req0 and req1 high together, frame0=0111, frame1=1110, held until gnt -> order gnt0, done0, gnt1, done1; both match=1; match_cnt=2; frames 6 cycles apart (GAP_CYCLES=0).
REQ-032 rst pulsed during third SHIFT cycle -> no done pulse, all outputs at reset values asynchronously; held req0 re-granted after release.
REQ-033 GAP_CYCLES=3, continuous req0 with 1001 for 300 frames -> 9-cycle frame period, match_cnt saturates at 255.
